// File: rtl/gnrl_pipe_arb_if.sv
// gnrl_pipe_arb_if
//   Bundle of the N requester valid/ready/data channels and the single
//   downstream valid/ready/data/id channel of gnrl_pipe_arb.
//   modport slave  : the arbiter side (consumes requests, produces the beat).
//   modport master : the environment side (produces requests, consumes beat).
// Parameters
//   N  : number of requesters (2..8)
//   DW : payload width per requester
//   IW : width of o_id, 2**IW >= N
interface gnrl_pipe_arb_if #(
  parameter int N  = 2,
  parameter int DW = 32,
  parameter int IW = 1
);
  logic [N-1:0]    i_vld;
  logic [N-1:0]    i_rdy;
  logic [N*DW-1:0] i_dat;
  logic            o_vld;
  logic            o_rdy;
  logic [DW-1:0]   o_dat;
  logic [IW-1:0]   o_id;

  modport master (
    output i_vld, i_dat, o_rdy,
    input  i_rdy, o_vld, o_dat, o_id
  );

  modport slave (
    input  i_vld, i_dat, o_rdy,
    output i_rdy, o_vld, o_dat, o_id
  );
endinterface

// File: rtl/gnrl_pipe_arb.sv
// gnrl_pipe_arb
//   N-to-1 valid/ready arbiter feeding a one-entry registered output stage.
//   At most one requester is granted per cycle; its payload and index are
//   captured into the output register. The register drains on o_vld & o_rdy
//   and may refill in the same cycle (one beat per cycle sustained).
// Ports
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : gnrl_pipe_arb_if.slave
//           i_vld[N], i_rdy[N], i_dat[N*DW]  requester side
//           o_vld, o_rdy, o_dat[DW], o_id[IW] downstream side
// Configuration
//   GNRL_ARB_RR_EN defined   : round-robin arbitration with a rotating
//                              priority pointer.
//   GNRL_ARB_RR_EN undefined : fixed priority, index 0 highest.
module gnrl_pipe_arb #(
  parameter int N  = 2,
  parameter int DW = 32,
  parameter int IW = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  gnrl_pipe_arb_if.slave bus
);

  // First set bit of vld, scanning upward from start and wrapping at N
  // (not at 2**IW). The inner loop keeps all indexing constant.
  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] vld,
                                           input logic [IW-1:0] start);
    logic [N-1:0] g;
    logic         done;
    int           pos;
    g    = '0;
    done = 1'b0;
    for (int j = 0; j < N; j++) begin
      pos = int'(start) + j;
      if (pos >= N) begin
        pos = pos - N;
      end
      for (int k = 0; k < N; k++) begin
        if (!done && (k == pos) && vld[k]) begin
          g[k] = 1'b1;
          done = 1'b1;
        end
      end
    end
    return g;
  endfunction

  // Binary index of a one-hot (or zero) grant vector.
  function automatic logic [IW-1:0] gnt_index(input logic [N-1:0] g);
    logic [IW-1:0] id;
    id = '0;
    for (int k = 0; k < N; k++) begin
      if (g[k]) begin
        id = IW'(k);
      end
    end
    return id;
  endfunction

  logic          vld_r;
  logic [DW-1:0] dat_r;
  logic [IW-1:0] id_r;
  logic [IW-1:0] ptr;

  logic [N-1:0]  gnt_s;
  logic [IW-1:0] gnt_id_s;
  logic [DW-1:0] sel_dat_s;
  logic          drain_s;
  logic          room_s;
  logic          acc_s;

  assign drain_s  = vld_r & bus.o_rdy;
  assign room_s   = ~vld_r | drain_s;
  assign gnt_s    = rr_pick(bus.i_vld, ptr);
  assign gnt_id_s = gnt_index(gnt_s);
  // gnt_s is a subset of i_vld, so a grant with room is an accept.
  assign acc_s    = (|gnt_s) & room_s;

  // Ready is deliberately not registered: it follows o_rdy in the same cycle.
  assign bus.i_rdy = gnt_s & {N{room_s}};

  // Payload mux selecting the granted requester slice.
  always_comb begin
    sel_dat_s = '0;
    for (int k = 0; k < N; k++) begin
      if (gnt_s[k]) begin
        sel_dat_s = bus.i_dat[k*DW +: DW];
      end else begin
        sel_dat_s = sel_dat_s;
      end
    end
  end

  // Output stage: accept wins over drain so a same-cycle refill stays valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r <= 1'b0;
      dat_r <= '0;
      id_r  <= '0;
    end else if (acc_s) begin
      vld_r <= 1'b1;
      dat_r <= sel_dat_s;
      id_r  <= gnt_id_s;
    end else if (drain_s) begin
      vld_r <= 1'b0;
    end else begin
      vld_r <= vld_r;
    end
  end

`ifdef GNRL_ARB_RR_EN
  // Priority pointer: moves past the winner only on a real accept, so a
  // grant stalled by a full output stage does not rotate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (acc_s) begin
      if (gnt_id_s == IW'(N-1)) begin
        ptr <= '0;
      end else begin
        ptr <= gnt_id_s + IW'(1);
      end
    end else begin
      ptr <= ptr;
    end
  end
`else
  // Fixed priority: scan always starts at requester 0.
  assign ptr = '0;
`endif

  assign bus.o_vld = vld_r;
  assign bus.o_dat = dat_r;
  assign bus.o_id  = id_r;

endmodule

// File: tb/tb_gnrl_pipe_arb.sv
// tb_gnrl_pipe_arb
//   Self-checking bench for gnrl_pipe_arb (N=3, DW=32, IW=2) in either
//   build (GNRL_ARB_RR_EN defined or not). A behavioural model tracks the
//   held beat and the priority start index; directed scenarios are followed
//   by a randomized phase.
module tb_gnrl_pipe_arb;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int IW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  // clock generator
  always #5 clk = ~clk;

  gnrl_pipe_arb_if #(.N(N), .DW(DW), .IW(IW)) bus();

  gnrl_pipe_arb #(.N(N), .DW(DW), .IW(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_chk = 0;
  int n_bad = 0;

  // reference model state
  logic          m_vld;
  logic [DW-1:0] m_dat;
  int            m_id;
  int            m_ptr;
  logic [DW-1:0] req_dat [N];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] pack_dat();
    logic [N*DW-1:0] p;
    p = '0;
    for (int k = 0; k < N; k++) p[k*DW +: DW] = req_dat[k];
    return p;
  endfunction

  // One clock cycle: drive at negedge, check before posedge, advance model.
  task automatic cycle(input logic [N-1:0] v, input logic r);
    int            g;
    int            k;
    logic          room;
    logic [N-1:0]  sh;
    logic [N-1:0]  exp_rdy;
    @(negedge clk);
    bus.i_vld = v;
    bus.i_dat = pack_dat();
    bus.o_rdy = r;
    #1;
    g = -1;
    for (int j = 0; j < N; j++) begin
      k  = (m_ptr + j) % N;
      sh = v >> k;
      if (g < 0 && sh[0]) g = k;
    end
    room    = !m_vld || r;
    exp_rdy = '0;
    if (g >= 0 && room) exp_rdy = N'(1) << g;
    check_eq("i_rdy", 64'(bus.i_rdy), 64'(exp_rdy));
    check_eq("o_vld", 64'(bus.o_vld), 64'(m_vld));
    check_eq("o_dat", 64'(bus.o_dat), 64'(m_dat));
    check_eq("o_id",  64'(bus.o_id),  64'(m_id));
    @(posedge clk);
    if (g >= 0 && room) begin
      m_vld = 1'b1;
      m_id  = g;
      for (int q = 0; q < N; q++) begin
        if (q == g) begin
          m_dat      = req_dat[q];
          req_dat[q] = $urandom();
        end
      end
`ifdef GNRL_ARB_RR_EN
      m_ptr = (g + 1) % N;
`endif
    end else if (m_vld && r) begin
      m_vld = 1'b0;
    end
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear at once.
  task automatic reset_pulse();
    @(negedge clk);
    bus.i_vld = '0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_o_vld", 64'(bus.o_vld), 64'd0);
    check_eq("rst_o_dat", 64'(bus.o_dat), 64'd0);
    check_eq("rst_o_id",  64'(bus.o_id),  64'd0);
    m_vld = 1'b0;
    m_dat = '0;
    m_id  = 0;
    m_ptr = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < N; k++) req_dat[k] = $urandom();
    m_vld = 1'b0;
    m_dat = '0;
    m_id  = 0;
    m_ptr = 0;
    bus.i_vld = '0;
    bus.i_dat = '0;
    bus.o_rdy = 1'b0;
    #23;
    rst_n = 1'b1;

    // idle after reset
    repeat (5) cycle(3'b000, 1'b0);

    // single beat from requester 1
    req_dat[1] = 32'hDEADBEEF;
    cycle(3'b010, 1'b1);
    #1;
    check_eq("single_vld", 64'(bus.o_vld), 64'd1);
    check_eq("single_dat", 64'(bus.o_dat), 64'hDEADBEEF);
    check_eq("single_id",  64'(bus.o_id),  64'd1);
    cycle(3'b000, 1'b1);

    // all requesters valid, downstream always ready
    reset_pulse();
    for (int i = 0; i < 7; i++) begin
      cycle(3'b111, 1'b1);
      #1;
      check_eq("burst_vld", 64'(bus.o_vld), 64'd1);
`ifdef GNRL_ARB_RR_EN
      check_eq("burst_id", 64'(bus.o_id), 64'(i % N));
`else
      check_eq("burst_id", 64'(bus.o_id), 64'd0);
`endif
    end

    // backpressure with the output stage full
    reset_pulse();
    cycle(3'b011, 1'b1);
    repeat (4) cycle(3'b011, 1'b0);
    cycle(3'b011, 1'b1);
    #1;
`ifdef GNRL_ARB_RR_EN
    check_eq("bp_release_id", 64'(bus.o_id), 64'd1);
`else
    check_eq("bp_release_id", 64'(bus.o_id), 64'd0);
`endif

    // requester 0 holds the bus, then drops out
    repeat (4) cycle(3'b011, 1'b1);
    cycle(3'b010, 1'b1);
    #1;
    check_eq("drop0_id", 64'(bus.o_id), 64'd1);

    // reset while a beat is held
    cycle(3'b111, 1'b0);
    cycle(3'b111, 1'b0);
    reset_pulse();
    cycle(3'b111, 1'b1);
    #1;
    check_eq("post_rst_id", 64'(bus.o_id), 64'd0);

    // randomized phase
    for (int i = 0; i < 400; i++) begin
      cycle(N'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
